// File: rtl/ramenable_mapper.sv
// ramenable_mapper: runtime-loaded CPU address to chip-select mapper.
// Banked lookup table with glitch-free bank switching at phi2 fall.
module ramenable_mapper #(
   parameter  int ADDR_W         = 16,
   parameter  int IDX_BITS       = 5,
   parameter  int CFG_W          = 4,
   parameter  int CH             = 2,
   parameter  int SWITCH_TIMEOUT = 255,
   localparam int TBL_AW         = CFG_W + 1 + IDX_BITS
) (
   input  logic              fpga_clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              phi2,
   input  logic              rwbar,
   input  logic [CFG_W-1:0]  configuration,
   input  logic              cfg_load,
   input  logic              tbl_reload,
   input  logic              tbl_wr_valid,
   output logic              tbl_wr_ready,
   input  logic [TBL_AW-1:0] tbl_wr_addr,
   input  logic [CH-1:0]     tbl_wr_data,
   input  logic              tbl_done,
   output logic [CH-1:0]     cs,
   output logic              we,
   output logic [CFG_W-1:0]  active_cfg,
   output logic              cfg_pending,
   output logic              running
);

   localparam int TBL_DEPTH = 2 ** TBL_AW;
   localparam int CNT_W     = $clog2(SWITCH_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SWITCH_TIMEOUT);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'b00,
      ST_RUN    = 2'b01,
      ST_SWITCH = 2'b10
   } state_t;

   state_t            r_state;
   logic [CFG_W-1:0]  r_active_cfg;
   logic [CFG_W-1:0]  r_pend_cfg;
   logic              r_cfg_pending;
   logic              r_running;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_phi2_s1;
   logic              r_phi2_s2;
   logic [CH-1:0]     r_entry_q;
   logic [CH-1:0]     r_tbl [TBL_DEPTH];

   logic [TBL_AW-1:0] w_idx;
   logic [CFG_W-1:0]  w_wr_bank;
   logic              w_wr_en;
   logic              w_fall;
   logic              w_unused_addr;

   assign w_idx     = {r_active_cfg, rwbar, address[ADDR_W-1 -: IDX_BITS]};
   assign w_wr_bank = tbl_wr_addr[TBL_AW-1 -: CFG_W];
   assign w_wr_en   = tbl_wr_valid & tbl_wr_ready;
   assign w_fall    = r_phi2_s2 & ~r_phi2_s1;
   assign w_unused_addr = ^address[ADDR_W-IDX_BITS-1:0];

   // Write acceptance: banks in use (active or pending) are protected.
   always_comb begin
      tbl_wr_ready = 1'b0;
      case (r_state)
         ST_LOAD:   tbl_wr_ready = 1'b1;
         ST_RUN:    tbl_wr_ready = (w_wr_bank != r_active_cfg);
         ST_SWITCH: tbl_wr_ready = (w_wr_bank != r_active_cfg) &&
                                   (w_wr_bank != r_pend_cfg);
         default:   tbl_wr_ready = 1'b0;
      endcase
   end

   // Table storage, deliberately not cleared by reset.
   always_ff @(posedge fpga_clk) begin
      if (w_wr_en)
         r_tbl[tbl_wr_addr] <= tbl_wr_data;
   end

   // Registered lookup of the current bank entry.
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n)
         r_entry_q <= '0;
      else
         r_entry_q <= r_tbl[w_idx];
   end

   // Two-flop synchroniser for the asynchronous phi2 clock.
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phi2_s1 <= 1'b0;
         r_phi2_s2 <= 1'b0;
      end else begin
         r_phi2_s1 <= phi2;
         r_phi2_s2 <= r_phi2_s1;
      end
   end

   // Load / run / bank-switch control with registered status outputs.
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_LOAD;
         r_active_cfg  <= '0;
         r_pend_cfg    <= '0;
         r_cfg_pending <= 1'b0;
         r_running     <= 1'b0;
         r_cnt         <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (tbl_done) begin
                  r_state      <= ST_RUN;
                  r_running    <= 1'b1;
                  r_active_cfg <= configuration;
               end
            end
            ST_RUN: begin
               if (tbl_reload) begin
                  r_state   <= ST_LOAD;
                  r_running <= 1'b0;
               end else if (cfg_load) begin
                  r_state       <= ST_SWITCH;
                  r_pend_cfg    <= configuration;
                  r_cfg_pending <= 1'b1;
                  r_cnt         <= '0;
               end
            end
            ST_SWITCH: begin
               if (tbl_reload) begin
                  r_state       <= ST_LOAD;
                  r_running     <= 1'b0;
                  r_cfg_pending <= 1'b0;
               end else if (w_fall || (r_cnt == CNT_MAX)) begin
                  r_state       <= ST_RUN;
                  r_active_cfg  <= r_pend_cfg;
                  r_cfg_pending <= 1'b0;
               end else begin
                  if (cfg_load)
                     r_pend_cfg <= configuration;
                  if (r_cnt != CNT_MAX)
                     r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state       <= ST_LOAD;
               r_running     <= 1'b0;
               r_cfg_pending <= 1'b0;
            end
         endcase
      end
   end

   assign cs          = {CH{r_running & phi2}} & r_entry_q;
   assign we          = r_running & phi2 & ~rwbar;
   assign active_cfg  = r_active_cfg;
   assign cfg_pending = r_cfg_pending;
   assign running     = r_running;

endmodule

// File: tb/tb_ramenable_mapper.sv
// tb_ramenable_mapper: directed checks of load, lookup, protection,
// bank switching on phi2 fall and timeout, and async reset.
module tb_ramenable_mapper;

   logic        fpga_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] address = '0;
   logic        phi2 = 1'b0;
   logic        rwbar = 1'b1;
   logic [3:0]  configuration = '0;
   logic        cfg_load = 1'b0;
   logic        tbl_reload = 1'b0;
   logic        tbl_wr_valid = 1'b0;
   logic        tbl_wr_ready;
   logic [9:0]  tbl_wr_addr = '0;
   logic [1:0]  tbl_wr_data = '0;
   logic        tbl_done = 1'b0;
   logic [1:0]  cs;
   logic        we;
   logic [3:0]  active_cfg;
   logic        cfg_pending;
   logic        running;

   int n_cmp = 0;
   int n_err = 0;
   int n_cyc;

   ramenable_mapper dut (
      .fpga_clk(fpga_clk), .rst_n(rst_n), .address(address),
      .phi2(phi2), .rwbar(rwbar), .configuration(configuration),
      .cfg_load(cfg_load), .tbl_reload(tbl_reload),
      .tbl_wr_valid(tbl_wr_valid), .tbl_wr_ready(tbl_wr_ready),
      .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .tbl_done(tbl_done), .cs(cs), .we(we), .active_cfg(active_cfg),
      .cfg_pending(cfg_pending), .running(running)
   );

   always #5 fpga_clk = ~fpga_clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge fpga_clk);
      @(negedge fpga_clk);
   endtask

   task automatic wr(input logic [9:0] a, input logic [1:0] d);
      tbl_wr_addr  = a;
      tbl_wr_data  = d;
      tbl_wr_valid = 1'b1;
      tick();
      tbl_wr_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_cs", 32'(cs), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_active", 32'(active_cfg), 0);
      chk("rst_pending", 32'(cfg_pending), 0);
      @(negedge fpga_clk);
      rst_n = 1'b1;
      tick();

      // LOAD: outputs forced off, writes accepted
      phi2 = 1'b1; rwbar = 1'b0; address = 16'h1234;
      tick();
      chk("load_cs", 32'(cs), 0);
      chk("load_we", 32'(we), 0);
      chk("load_ready", 32'(tbl_wr_ready), 1);

      wr(10'h0FF, 2'b11);
      wr(10'h0DF, 2'b01);
      wr(10'h0C5, 2'b10);

      // Last write coincides with tbl_done
      configuration = 4'd3;
      tbl_done = 1'b1;
      tbl_wr_addr = 10'h0E0; tbl_wr_data = 2'b10; tbl_wr_valid = 1'b1;
      tick();
      tbl_done = 1'b0; tbl_wr_valid = 1'b0;
      chk("run_running", 32'(running), 1);
      chk("run_active", 32'(active_cfg), 3);

      // Lookup bank3 rw1 idx31
      address = 16'hF800; rwbar = 1'b1; phi2 = 1'b1;
      tick();
      chk("lk_f800_r", 32'(cs), 32'h3);
      chk("lk_f800_we", 32'(we), 0);
      phi2 = 1'b0;
      #1;
      chk("lk_phi2_gate", 32'(cs), 0);
      phi2 = 1'b1; rwbar = 1'b0;
      tick();
      chk("lk_f800_w", 32'(cs), 32'h1);
      chk("lk_we", 32'(we), 1);

      // Entry written together with tbl_done
      address = 16'h0000; rwbar = 1'b1;
      tick();
      chk("lk_done_wr", 32'(cs), 32'h2);

      // Active bank protected
      tbl_wr_addr = 10'h0C5; tbl_wr_data = 2'b01; tbl_wr_valid = 1'b1;
      #1;
      chk("prot_ready", 32'(tbl_wr_ready), 0);
      tick();
      tbl_wr_valid = 1'b0;
      address = 16'h2800; rwbar = 1'b0;
      tick();
      chk("prot_unchanged", 32'(cs), 32'h2);

      // Other bank writable
      tbl_wr_addr = 10'h140;
      #1;
      chk("bank5_ready", 32'(tbl_wr_ready), 1);
      wr(10'h140, 2'b01);

      // Switch to bank 5 on phi2 fall
      configuration = 4'd5; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      chk("sw_pending", 32'(cfg_pending), 1);
      chk("sw_active_old", 32'(active_cfg), 3);
      tbl_wr_addr = 10'h150;
      #1;
      chk("sw_pend_prot", 32'(tbl_wr_ready), 0);
      tbl_wr_addr = 10'h1C0;
      #1;
      chk("sw_other_ready", 32'(tbl_wr_ready), 1);
      tick(); tick();
      chk("sw_hold", 32'(active_cfg), 3);
      chk("sw_old_bank_cs", 32'(cs), 32'h2);
      phi2 = 1'b0;
      tick();
      chk("sw_fall_1", 32'(active_cfg), 3);
      tick();
      chk("sw_fall_2", 32'(active_cfg), 5);
      chk("sw_pending_clr", 32'(cfg_pending), 0);
      address = 16'h0000; rwbar = 1'b0; phi2 = 1'b1;
      tick();
      chk("bank5_lookup", 32'(cs), 32'h1);
      tick();

      // Timeout switch with phi2 held high
      configuration = 4'd3; cfg_load = 1'b1;
      @(posedge fpga_clk);
      @(negedge fpga_clk);
      cfg_load = 1'b0;
      n_cyc = 0;
      while (active_cfg != 4'd3 && n_cyc < 400) begin
         tick();
         n_cyc++;
      end
      chk("timeout_cycles", 32'(n_cyc), 256);
      chk("timeout_pending", 32'(cfg_pending), 0);

      // Async reset mid-switch
      configuration = 4'd5; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      tick(); tick();
      chk("mid_sw_pending", 32'(cfg_pending), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_cs", 32'(cs), 0);
      chk("ar_running", 32'(running), 0);
      chk("ar_pending", 32'(cfg_pending), 0);
      chk("ar_active", 32'(active_cfg), 0);
      @(negedge fpga_clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(tbl_wr_ready), 1);
      chk("post_rst_running", 32'(running), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
